alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_pkg.sv | 83 ++++++++
 rtl/reg_file_2r1w.sv | 31 +++
 rtl/alu_issue_ctrl.sv | 122 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared decode constants, ALU select codes, FSM encoding and the instruction
// decoder used by the issue controller.
package alu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;

  localparam logic [2:0] ALU_ADDSUB = 3'b000;
  localparam logic [2:0] ALU_SLLSRA = 3'b001;
  localparam logic [2:0] ALU_SLT    = 3'b010;
  localparam logic [2:0] ALU_MULDIV = 3'b011;

  typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_EXEC, ST_WB} state_e;

  typedef struct packed {
    logic       ill;
    logic [2:0] alu_sel;
    logic       alu_type;
    logic       shift;
    logic       use_imm;
  } dec_t;

  // Base ops pass funct3 straight through; only SLT(I)U, SUB, SRA and M ops remap.
  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [6:0] f7;
    logic [2:0] f3;
    f7         = ins[31:25];
    f3         = ins[14:12];
    d.ill      = 1'b0;
    d.alu_sel  = f3;
    d.alu_type = 1'b0;
    d.shift    = 1'b0;
    d.use_imm  = 1'b0;
    if (ins[6:0] == OPC_R) begin
      case (f7)
        F7_BASE: begin
          if (f3 == F3_SLTU) begin d.alu_sel = ALU_SLT; d.alu_type = 1'b1; end
          d.shift = (f3 == F3_SLL) || (f3 == F3_SR);
        end
        F7_ALT: begin
          d.alu_type = 1'b1;
          if (f3 == F3_ADD) d.alu_sel = ALU_ADDSUB;
          else if (f3 == F3_SR) begin d.alu_sel = ALU_SLLSRA; d.shift = 1'b1; end
          else d.ill = 1'b1;
        end
        F7_MULDIV: begin
          d.alu_sel  = ALU_MULDIV;
          d.alu_type = (f3 == F3_ADD);
          d.ill      = (f3 != F3_ADD) && (f3 != F3_XOR);
        end
        default: d.ill = 1'b1;
      endcase
    end else if (ins[6:0] == OPC_I) begin
      d.use_imm = 1'b1;
      case (f3)
        F3_SLTU: begin d.alu_sel = ALU_SLT; d.alu_type = 1'b1; end
        F3_SLL: begin d.shift = 1'b1; d.ill = (f7 != F7_BASE); end
        F3_SR: begin
          d.shift = 1'b1;
          if (f7 == F7_ALT) begin d.alu_sel = ALU_SLLSRA; d.alu_type = 1'b1; end
          else d.ill = (f7 != F7_BASE);
        end
        default: ;
      endcase
    end else begin
      d.ill = 1'b1;
    end
    return d;
  endfunction
endpackage

// File: rtl/reg_file_2r1w.sv
// 32-entry register file: two async read ports, one sync write port, debug read.
// Entry 0 is never written and every read of address 0 returns zero.
module reg_file_2r1w
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [DATA_W-1:0] dbg_data_o
);
  logic [DATA_W-1:0] regs_q [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < (1 << ADDR_W); i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o   = (raddr1_i   == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o   = (raddr2_i   == '0) ? '0 : regs_q[raddr2_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];
endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue RV32 integer controller: accepts one instruction, drives an
// external combinational ALU and writes the result back, four cycles per op.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [DATA_W-1:0] operand1,
  output logic [DATA_W-1:0] operand2,
  output logic [2:0]        funct3_alu,
  output logic              Type_alu,
  input  logic [DATA_W-1:0] result,
  output logic              done_valid,
  output logic [4:0]        done_rd,
  output logic [DATA_W-1:0] done_data,
  output logic              illegal,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  state_e            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d, hold_q, hold_d;
  logic [2:0]        sel_q, sel_d;
  logic              type_q, type_d;
  logic              rf_we;
  logic [DATA_W-1:0] rs1_data, rs2_data, op2_sel;
  dec_t              dec;

  reg_file_2r1w u_rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (rf_we),
    .waddr_i    (instr_q[11:7]),
    .wdata_i    (hold_q),
    .raddr1_i   (instr_q[19:15]),
    .raddr2_i   (instr_q[24:20]),
    .dbg_addr_i (dbg_addr),
    .rdata1_o   (rs1_data),
    .rdata2_o   (rs2_data),
    .dbg_data_o (dbg_data)
  );

  assign dec     = decode(instr_q);
  assign op2_sel = dec.shift   ? {27'b0, (dec.use_imm ? instr_q[24:20] : rs2_data[4:0])} :
                   dec.use_imm ? {{20{instr_q[31]}}, instr_q[31:20]} : rs2_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      sel_q   <= '0;
      type_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sel_q   <= sel_d;
      type_q  <= type_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    sel_d       = sel_q;
    type_d      = type_q;
    hold_d      = hold_q;
    instr_ready = 1'b0;
    illegal     = 1'b0;
    done_valid  = 1'b0;
    rf_we       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec.ill) begin
          illegal = 1'b1;
          state_d = ST_IDLE;
        end else begin
          op1_d   = rs1_data;
          op2_d   = op2_sel;
          sel_d   = dec.alu_sel;
          type_d  = dec.alu_type;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        hold_d  = result;
        state_d = ST_WB;
      end
      ST_WB: begin
        // Write lands on the edge leaving WB, so debug reads see the old value here.
        done_valid = 1'b1;
        rf_we      = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign operand1   = op1_q;
  assign operand2   = op2_q;
  assign funct3_alu = sel_q;
  assign Type_alu   = type_q;
  assign done_rd    = instr_q[11:7];
  assign done_data  = hold_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: an RV32 semantic model predicts each
// instruction's outcome, and a behavioural ALU answers the DUT's select codes.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [31:0] operand1, operand2, result, done_data, dbg_data;
  logic [2:0]  funct3_alu;
  logic        Type_alu, done_valid, illegal;
  logic [4:0]  done_rd;
  logic [4:0]  dbg_addr = '0;

  int checks = 0;
  int failures = 0;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .operand1    (operand1),
    .operand2    (operand2),
    .funct3_alu  (funct3_alu),
    .Type_alu    (Type_alu),
    .result      (result),
    .done_valid  (done_valid),
    .done_rd     (done_rd),
    .done_data   (done_data),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  logic signed [31:0] alu_q;
  always_comb begin
    alu_q = '0;
    if (operand2 != '0) alu_q = $signed(operand1) / $signed(operand2);
    case ({funct3_alu, Type_alu})
      4'b0000: result = operand1 + operand2;
      4'b0001: result = operand1 - operand2;
      4'b0010: result = operand1 << operand2[4:0];
      4'b0011: result = $signed(operand1) >>> operand2[4:0];
      4'b0100: result = {31'b0, $signed(operand1) < $signed(operand2)};
      4'b0101: result = {31'b0, operand1 < operand2};
      4'b0110: result = (operand2 == '0) ? 32'hFFFF_FFFF : alu_q;
      4'b0111: result = operand1 * operand2;
      4'b1000: result = operand1 ^ operand2;
      4'b1010: result = operand1 >> operand2[4:0];
      4'b1100: result = operand1 | operand2;
      4'b1110: result = operand1 & operand2;
      default: result = '0;
    endcase
  end

  typedef struct packed {
    logic        ill;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  f3;
    logic        t;
    logic [31:0] op2;
    logic [31:0] old_v;
    logic [31:0] new_v;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mregs [0:31];

  int          done_k, ill_k, done_cnt, ill_cnt;
  logic [4:1]  rdy;
  logic [4:0]  o_rd;
  logic [31:0] o_data, o_op2, dbg_old, dbg_new;
  logic [2:0]  o_f3;
  logic        o_t;

  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  task automatic push_exp(input logic [31:0] ins);
    exp_t               e;
    logic [31:0]        a, b, imm;
    logic [4:0]         sh;
    logic [6:0]         f7;
    logic [2:0]         f3;
    logic signed [31:0] sa, sb;
    a = mregs[ins[19:15]]; b = mregs[ins[24:20]];
    imm = {{20{ins[31]}}, ins[31:20]};
    f7 = ins[31:25]; f3 = ins[14:12]; sa = a;
    e = '0; e.rd = ins[11:7]; e.ill = 1'b1; e.old_v = mregs[ins[11:7]];
    if (ins[6:0] == 7'b0110011) begin
      sb = b; sh = b[4:0]; e.op2 = b; e.ill = 1'b0;
      case ({f7, f3})
        {7'h00, 3'd0}: begin e.data = a + b;  e.f3 = 3'd0; e.t = 1'b0; end
        {7'h20, 3'd0}: begin e.data = a - b;  e.f3 = 3'd0; e.t = 1'b1; end
        {7'h00, 3'd1}: begin e.data = a << sh; e.f3 = 3'd1; e.t = 1'b0; e.op2 = {27'b0, sh}; end
        {7'h00, 3'd2}: begin e.data = {31'b0, sa < sb}; e.f3 = 3'd2; e.t = 1'b0; end
        {7'h00, 3'd3}: begin e.data = {31'b0, a < b};   e.f3 = 3'd2; e.t = 1'b1; end
        {7'h00, 3'd4}: begin e.data = a ^ b;  e.f3 = 3'd4; e.t = 1'b0; end
        {7'h00, 3'd5}: begin e.data = a >> sh; e.f3 = 3'd5; e.t = 1'b0; e.op2 = {27'b0, sh}; end
        {7'h20, 3'd5}: begin e.data = sa >>> sh; e.f3 = 3'd1; e.t = 1'b1; e.op2 = {27'b0, sh}; end
        {7'h00, 3'd6}: begin e.data = a | b;  e.f3 = 3'd6; e.t = 1'b0; end
        {7'h00, 3'd7}: begin e.data = a & b;  e.f3 = 3'd7; e.t = 1'b0; end
        {7'h01, 3'd0}: begin e.data = a * b;  e.f3 = 3'd3; e.t = 1'b1; end
        {7'h01, 3'd4}: begin e.data = (b == '0) ? 32'hFFFF_FFFF : sa / sb; e.f3 = 3'd3; e.t = 1'b0; end
        default: e.ill = 1'b1;
      endcase
    end else if (ins[6:0] == 7'b0010011) begin
      sb = imm; sh = ins[24:20]; e.op2 = imm; e.ill = 1'b0;
      case (f3)
        3'd0: begin e.data = a + imm; e.f3 = 3'd0; e.t = 1'b0; end
        3'd2: begin e.data = {31'b0, sa < sb}; e.f3 = 3'd2; e.t = 1'b0; end
        3'd3: begin e.data = {31'b0, a < imm}; e.f3 = 3'd2; e.t = 1'b1; end
        3'd4: begin e.data = a ^ imm; e.f3 = 3'd4; e.t = 1'b0; end
        3'd6: begin e.data = a | imm; e.f3 = 3'd6; e.t = 1'b0; end
        3'd7: begin e.data = a & imm; e.f3 = 3'd7; e.t = 1'b0; end
        3'd1: begin
          e.op2 = {27'b0, sh};
          if (f7 == 7'h00) begin e.data = a << sh; e.f3 = 3'd1; e.t = 1'b0; end
          else e.ill = 1'b1;
        end
        default: begin
          e.op2 = {27'b0, sh};
          if (f7 == 7'h00) begin e.data = a >> sh; e.f3 = 3'd5; e.t = 1'b0; end
          else if (f7 == 7'h20) begin e.data = sa >>> sh; e.f3 = 3'd1; e.t = 1'b1; end
          else e.ill = 1'b1;
        end
      endcase
    end
    if (!e.ill && e.rd != 5'd0) mregs[e.rd] = e.data;
    e.new_v = mregs[e.rd];
    exp_q.push_back(e);
  endtask

  // Offers one instruction and records what the DUT shows over the next four cycles.
  task automatic issue(input logic [31:0] ins);
    int guard;
    guard = 0;
    while (!instr_ready && guard < 10) begin @(negedge clk); guard++; end
    dbg_addr = ins[11:7]; instr = ins; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = $urandom;
    done_k = 0; ill_k = 0; done_cnt = 0; ill_cnt = 0; rdy = '0;
    o_rd = '0; o_data = '0; o_op2 = '0; o_f3 = '0; o_t = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      rdy[k] = instr_ready;
      if (done_valid) begin
        done_cnt++;
        if (done_k == 0) done_k = k;
        o_rd = done_rd; o_data = done_data; o_op2 = operand2; o_f3 = funct3_alu; o_t = Type_alu;
      end
      if (illegal) begin ill_cnt++; if (ill_k == 0) ill_k = k; end
      if (k == 3) dbg_old = dbg_data;
      if (k == 4) dbg_new = dbg_data;
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({operand1, operand2, funct3_alu, Type_alu, done_rd, done_data} !== '0) begin
      failures++; $display("FAIL reset_outputs: got op1=%h op2=%h f3=%b t=%b rd=%0d data=%h want all 0",
                           operand1, operand2, funct3_alu, Type_alu, done_rd, done_data);
    end
    checks++;
    if ({done_valid, illegal} !== 2'b00) begin
      failures++; $display("FAIL reset_pulses: got done_valid=%b illegal=%b want 0 0", done_valid, illegal);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    for (int r = 0; r < 32; r++) begin
      dbg_addr = r[4:0]; #1;
      checks++;
      if (dbg_data !== '0) begin failures++; $display("FAIL reset_reg x%0d: got %h want 0", r, dbg_data); end
    end
  endtask

  task automatic test_alu_ops;
    logic [31:0] prog[$];
    exp_t        e;
    prog.push_back(32'hFFB0_0093);                          // ADDI x1,x0,-5
    prog.push_back(i_ins(12'd7, 5'd0, 3'd0, 5'd1));
    prog.push_back(i_ins(12'd3, 5'd0, 3'd0, 5'd2));
    prog.push_back(r_ins(7'h20, 5'd2, 5'd1, 3'd0, 5'd3));   // SUB
    prog.push_back(r_ins(7'h00, 5'd2, 5'd1, 3'd3, 5'd5));   // SLTU
    prog.push_back(r_ins(7'h01, 5'd2, 5'd1, 3'd0, 5'd6));   // MUL
    prog.push_back(r_ins(7'h01, 5'd2, 5'd1, 3'd4, 5'd9));   // DIV
    prog.push_back(r_ins(7'h00, 5'd2, 5'd1, 3'd4, 5'd10));  // XOR
    prog.push_back(r_ins(7'h00, 5'd2, 5'd1, 3'd6, 5'd11));  // OR
    prog.push_back(r_ins(7'h00, 5'd2, 5'd1, 3'd7, 5'd12));  // AND
    prog.push_back(r_ins(7'h00, 5'd1, 5'd2, 3'd2, 5'd13));  // SLT
    prog.push_back(r_ins(7'h00, 5'd2, 5'd1, 3'd1, 5'd14));  // SLL
    prog.push_back(r_ins(7'h00, 5'd2, 5'd6, 3'd5, 5'd15));  // SRL
    prog.push_back(i_ins(12'hFFF, 5'd1, 3'd4, 5'd16));      // XORI
    prog.push_back(i_ins(12'h005, 5'd1, 3'd7, 5'd17));      // ANDI
    prog.push_back(i_ins(12'h800, 5'd2, 3'd6, 5'd18));      // ORI
    prog.push_back(i_ins(12'hFFF, 5'd3, 3'd2, 5'd19));      // SLTI
    prog.push_back(i_ins(12'hFFF, 5'd3, 3'd3, 5'd20));      // SLTIU
    prog.push_back(i_ins(12'h004, 5'd1, 3'd1, 5'd21));      // SLLI
    prog.push_back(i_ins(12'h01C, 5'd16, 3'd5, 5'd22));     // SRLI
    prog.push_back(i_ins(12'h402, 5'd16, 3'd5, 5'd23));     // SRAI
    prog.push_back(i_ins(12'd1, 5'd0, 3'd0, 5'd1));
    prog.push_back(i_ins(12'h01F, 5'd1, 3'd1, 5'd1));
    prog.push_back(r_ins(7'h20, 5'd2, 5'd1, 3'd5, 5'd4));   // SRA
    foreach (prog[i]) begin
      push_exp(prog[i]);
      issue(prog[i]);
      e = exp_q.pop_front();
      checks++;
      if (done_k !== 3 || done_cnt !== 1 || ill_cnt !== 0) begin
        failures++; $display("FAIL op%0d timing: got done_k=%0d done_cnt=%0d ill_cnt=%0d want 3 1 0",
                             i, done_k, done_cnt, ill_cnt);
      end
      checks++;
      if (o_rd !== e.rd || o_data !== e.data) begin
        failures++; $display("FAIL op%0d writeback: got rd=%0d data=%h want rd=%0d data=%h", i, o_rd, o_data, e.rd, e.data);
      end
      checks++;
      if (o_f3 !== e.f3 || o_t !== e.t || o_op2 !== e.op2) begin
        failures++; $display("FAIL op%0d alu_drive: got f3=%b t=%b op2=%h want f3=%b t=%b op2=%h",
                             i, o_f3, o_t, o_op2, e.f3, e.t, e.op2);
      end
      checks++;
      if (dbg_old !== e.old_v || dbg_new !== e.new_v) begin
        failures++; $display("FAIL op%0d dbg: got old=%h new=%h want old=%h new=%h", i, dbg_old, dbg_new, e.old_v, e.new_v);
      end
      checks++;
      if (rdy !== 4'b1000) begin failures++; $display("FAIL op%0d ready: got %b want 1000", i, rdy); end
    end
  endtask

  task automatic test_illegal;
    logic [31:0] prog[$];
    exp_t        e;
    prog.push_back(r_ins(7'h03, 5'd2, 5'd1, 3'd0, 5'd7));
    prog.push_back(r_ins(7'h20, 5'd2, 5'd1, 3'd1, 5'd7));
    prog.push_back(r_ins(7'h01, 5'd2, 5'd1, 3'd2, 5'd7));
    prog.push_back(i_ins(12'h404, 5'd1, 3'd1, 5'd7));       // SLLI with funct7 0100000
    prog.push_back(i_ins(12'h022, 5'd1, 3'd5, 5'd7));       // shift-right funct7 0000001
    prog.push_back(32'h0000_8383);                          // load opcode
    prog.push_back(32'h0000_73B7);                          // LUI opcode
    foreach (prog[i]) begin
      push_exp(prog[i]);
      issue(prog[i]);
      e = exp_q.pop_front();
      checks++;
      if (e.ill !== 1'b1 || ill_k !== 1 || ill_cnt !== 1 || done_cnt !== 0) begin
        failures++; $display("FAIL ill%0d pulse: got ill_k=%0d ill_cnt=%0d done_cnt=%0d want 1 1 0",
                             i, ill_k, ill_cnt, done_cnt);
      end
      checks++;
      if (rdy !== 4'b1110) begin failures++; $display("FAIL ill%0d ready: got %b want 1110", i, rdy); end
      checks++;
      if (dbg_new !== e.old_v) begin failures++; $display("FAIL ill%0d rd_kept: got %h want %h", i, dbg_new, e.old_v); end
    end
    for (int r = 0; r < 32; r++) begin
      dbg_addr = r[4:0]; #1;
      checks++;
      if (dbg_data !== mregs[r]) begin failures++; $display("FAIL ill_regs x%0d: got %h want %h", r, dbg_data, mregs[r]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] prog[$];
    exp_t        e;
    prog.push_back(i_ins(12'd100, 5'd0, 3'd0, 5'd25));
    prog.push_back(r_ins(7'h00, 5'd25, 5'd25, 3'd0, 5'd26));
    prog.push_back(r_ins(7'h20, 5'd1, 5'd26, 3'd0, 5'd27));
    prog.push_back(r_ins(7'h01, 5'd27, 5'd26, 3'd0, 5'd28));
    foreach (prog[i]) begin
      push_exp(prog[i]);
      issue(prog[i]);
      e = exp_q.pop_front();
      checks++;
      if (done_k !== 3 || o_data !== e.data || dbg_new !== e.new_v) begin
        failures++; $display("FAIL b2b%0d: got done_k=%0d data=%h reg=%h want 3 %h %h", i, done_k, o_data, dbg_new, e.data, e.new_v);
      end
      checks++;
      if (rdy !== 4'b1000) begin failures++; $display("FAIL b2b%0d ready: got %b want 1000", i, rdy); end
    end
  endtask

  task automatic test_x0;
    exp_t e;
    push_exp(i_ins(12'd9, 5'd0, 3'd0, 5'd0));
    issue(i_ins(12'd9, 5'd0, 3'd0, 5'd0));
    e = exp_q.pop_front();
    checks++;
    if (done_cnt !== 1 || o_rd !== 5'd0 || o_data !== e.data) begin
      failures++; $display("FAIL x0_done: got cnt=%0d rd=%0d data=%h want 1 0 %h", done_cnt, o_rd, o_data, e.data);
    end
    checks++;
    if (dbg_old !== 32'd0 || dbg_new !== e.new_v) begin
      failures++; $display("FAIL x0_read: got old=%h new=%h want 0 %h", dbg_old, dbg_new, e.new_v);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    dbg_addr = 5'd24;
    while (!instr_ready) @(negedge clk);
    instr = i_ins(12'd5, 5'd2, 3'd0, 5'd24); instr_valid = 1'b1;
    @(posedge clk); #1; instr_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0; #1;
    checks++;
    if ({operand1, operand2, done_data, done_valid} !== '0 || instr_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_outputs: got op1=%h op2=%h data=%h dv=%b rdy=%b want 0 0 0 0 1",
                           operand1, operand2, done_data, done_valid, instr_ready);
    end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin @(negedge clk); if (done_valid) seen++; end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL rst_mid_done: got %0d pulses want 0", seen); end
    checks++;
    if (instr_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready: got %b want 1", instr_ready); end
    for (int r = 0; r < 32; r++) begin
      mregs[r] = '0;
      dbg_addr = r[4:0]; #1;
      checks++;
      if (dbg_data !== '0) begin failures++; $display("FAIL rst_mid_reg x%0d: got %h want 0", r, dbg_data); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int r = 0; r < 32; r++) mregs[r] = '0;
    test_reset();
    test_alu_ops();
    test_illegal();
    test_back_to_back();
    test_x0();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
